// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU memory stage: memory opcodes, the
// load/store controller state encoding, and a small opcode decoder.
package cpu_pkg;

    localparam logic [3:0] OP_LDR = 4'b1001;
    localparam logic [3:0] OP_STR = 4'b1010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    // True for opcodes that need the RAM bus (LDR or STR).
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LDR) || (op == OP_STR);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Shared RAM bus between the memory-access controller (master) and the RAM
// (slave).
//   mem_addr/mem_en/mem_rw/mem_wdata : request, driven by the controller
//   mem_rdata/mem_ready              : response, driven by the RAM
// mem_rw: 1 = read, 0 = write.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_en;
    logic              mem_rw;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_addr, mem_en, mem_rw, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_addr, mem_en, mem_rw, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_access_ctrl_wait_counter.sv
// Access-cycle counter for the memory-access controller.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : synchronous clear (wins over en)
//   en          : increment this cycle
//   wait_met    : count >= WAIT_STATES, RAM completion may be sampled
//   timeout_hit : count == TIMEOUT-1, last cycle before abort
module wait_counter #(
    parameter int WAIT_STATES = 0,
    parameter int TIMEOUT     = 64,
    parameter int CNT_W       = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic wait_met,
    output logic timeout_hit
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)     cnt_d = '0;
        else if (en) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // With no wait states the comparison is trivially true; tie it off so
    // no always-true unsigned compare is built.
    if (WAIT_STATES == 0) begin : g_no_wait
        assign wait_met = 1'b1;
    end else begin : g_wait
        assign wait_met = (cnt_q >= CNT_W'(WAIT_STATES));
    end

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle load/store controller for the CPU memory stage.
// Arbitrates the shared RAM bus between instruction fetch (IDLE/DONE) and
// data access (ACCESS), stalls the pipeline while an access is outstanding,
// and returns a registered write-back value (load data or ALU result).
//   clk, rst_n            : clock, asynchronous active-low reset
//   op_valid, opcode      : memory-stage instruction
//   source1               : address operand (low ADDR_W bits used)
//   source2               : store data
//   alu_result            : write-back value for non-memory ops
//   fetch_addr            : PC, drives the bus when fetch owns it
//   mem                   : RAM bus (master side)
//   address_sel           : 1 = data access owns the bus
//   ldr_sel               : write-back source is load data
//   stall                 : freeze fetch/decode, hold memory-stage inputs
//   wb_valid, wb_data     : one-cycle write-back strobe and value
//   err                   : one-cycle access timeout pulse
module mem_access_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 0,
    parameter int TIMEOUT     = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] source1,
    input  logic [DATA_W-1:0] source2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [ADDR_W-1:0] fetch_addr,
    mem_access_ctrl_if.master mem,
    output logic              address_sel,
    output logic              ldr_sel,
    output logic              stall,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic              err
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              is_load_q, is_load_d;
    logic              wb_valid_q, wb_valid_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              ldr_sel_q, ldr_sel_d;
    logic              err_q, err_d;

    logic accept, in_access, complete, timeout;
    logic wait_met, timeout_hit;

    assign accept    = (state_q == IDLE) && op_valid && is_mem_op(opcode);
    assign in_access = (state_q == ACCESS);
    // mem_ready only counts once the minimum wait has elapsed.
    assign complete  = in_access && wait_met && mem.mem_ready;
    // Completion on the last allowed cycle still wins over the abort.
    assign timeout   = in_access && !complete && timeout_hit;

    wait_counter #(
        .WAIT_STATES (WAIT_STATES),
        .TIMEOUT     (TIMEOUT)
    ) u_wait_counter (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (accept),
        .en          (in_access),
        .wait_met    (wait_met),
        .timeout_hit (timeout_hit)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_load_d  = is_load_q;
        wb_data_d  = wb_data_q;
        ldr_sel_d  = ldr_sel_q;
        wb_valid_d = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = ACCESS;
                    addr_d    = source1[ADDR_W-1:0];
                    wdata_d   = source2;
                    is_load_d = (opcode == OP_LDR);
                end else if (op_valid) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = alu_result;
                    ldr_sel_d  = 1'b0;
                end
            end
            ACCESS: begin
                if (complete) begin
                    state_d = DONE;
                    // Write-back is registered here so it is visible in DONE.
                    if (is_load_q) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = mem.mem_rdata;
                        ldr_sel_d  = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_load_q  <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            ldr_sel_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_load_q  <= is_load_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            ldr_sel_q  <= ldr_sel_d;
            err_q      <= err_d;
        end
    end

    // Fetch/data bus mux: the bus belongs to fetch except during ACCESS.
    assign mem.mem_addr  = in_access ? addr_q : fetch_addr;
    assign mem.mem_en    = 1'b1;
    assign mem.mem_rw    = in_access ? is_load_q : 1'b1;
    assign mem.mem_wdata = wdata_q;

    assign address_sel = in_access;
    assign stall       = accept || in_access;
    assign wb_valid    = wb_valid_q;
    assign wb_data     = wb_data_q;
    assign ldr_sel     = ldr_sel_q;
    assign err         = err_q;

    // Address bits above ADDR_W are intentionally ignored.
    if (DATA_W > ADDR_W) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^source1[DATA_W-1:ADDR_W];
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl. dut_a: WAIT_STATES=0, TIMEOUT=8 (loads, ALU,
// timeout, reset). dut_b: WAIT_STATES=3 (store). Write-backs of dut_a are
// checked against a queue of expected values filled when stimulus is driven.
module tb_mem_access_ctrl;
    import cpu_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;

    typedef struct {
        logic [DW-1:0] data;
        logic          ldr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          op_valid_a, op_valid_b;
    logic [3:0]    opcode;
    logic [DW-1:0] source1, source2, alu_result;
    logic [AW-1:0] fetch_addr;

    logic          a_sel, a_ldr, a_stall, a_wbv, a_err;
    logic [DW-1:0] a_wbd;
    logic          b_sel, b_ldr, b_stall, b_wbv, b_err;
    logic [DW-1:0] b_wbd;

    mem_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) mif_a ();
    mem_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) mif_b ();

    mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(0), .TIMEOUT(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid_a), .opcode(opcode),
        .source1(source1), .source2(source2), .alu_result(alu_result),
        .fetch_addr(fetch_addr), .mem(mif_a), .address_sel(a_sel),
        .ldr_sel(a_ldr), .stall(a_stall), .wb_valid(a_wbv), .wb_data(a_wbd),
        .err(a_err)
    );

    mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(3), .TIMEOUT(64)) dut_b (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid_b), .opcode(opcode),
        .source1(source1), .source2(source2), .alu_result(alu_result),
        .fetch_addr(fetch_addr), .mem(mif_b), .address_sel(b_sel),
        .ldr_sel(b_ldr), .stall(b_stall), .wb_valid(b_wbv), .wb_data(b_wbd),
        .err(b_err)
    );

    int   errors = 0;
    int   checks = 0;
    int   err_cnt = 0;
    exp_t sb[$];

    // Scoreboard: every dut_a write-back must match the oldest expectation.
    always @(negedge clk) begin
        if (a_err) err_cnt++;
        if (a_wbv || a_err) begin
            checks++;
            if (a_wbv && a_err) begin
                errors++;
                $display("FAIL wb_err_overlap: wb_valid and err both high");
            end
        end
        if (a_wbv) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_wb: got data=%h ldr=%b, want no write-back", a_wbd, a_ldr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (a_wbd !== e.data || a_ldr !== e.ldr) begin
                    errors++;
                    $display("FAIL wb_data: got data=%h ldr=%b, want data=%h ldr=%b", a_wbd, a_ldr, e.data, e.ldr);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; op_valid_a = 1'b0; op_valid_b = 1'b0; opcode = 4'h0;
        source1 = '0; source2 = '0; alu_result = '0; fetch_addr = 16'h0040;
        mif_a.mem_rdata = '0; mif_a.mem_ready = 1'b0;
        mif_b.mem_rdata = '0; mif_b.mem_ready = 1'b0;
        #12;
        checks++;
        if ({mif_a.mem_addr, mif_a.mem_en, mif_a.mem_rw, a_sel, a_stall, a_wbv, a_ldr, a_err} !==
            {16'h0040, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got addr=%h en=%b rw=%b sel=%b stall=%b wbv=%b ldr=%b err=%b",
                     mif_a.mem_addr, mif_a.mem_en, mif_a.mem_rw, a_sel, a_stall, a_wbv, a_ldr, a_err);
        end
        checks++;
        if (a_wbd !== 32'h0 || mif_a.mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got wb_data=%h wdata=%h, want 0", a_wbd, mif_a.mem_wdata);
        end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({mif_a.mem_addr, mif_a.mem_rw, a_sel, a_stall, a_wbv} !== {16'h0040, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL idle_outputs: got addr=%h rw=%b sel=%b stall=%b wbv=%b",
                     mif_a.mem_addr, mif_a.mem_rw, a_sel, a_stall, a_wbv);
        end
    endtask

    task automatic test_load();
        step();
        opcode = OP_LDR; source1 = 32'h0001_1234;
        mif_a.mem_ready = 1'b1; mif_a.mem_rdata = 32'hDEAD_BEEF;
        op_valid_a = 1'b1;
        sb.push_back('{32'hDEAD_BEEF, 1'b1});
        @(negedge clk);
        checks++;
        if ({a_stall, a_sel, mif_a.mem_addr} !== {1'b1, 1'b0, 16'h0040}) begin
            errors++;
            $display("FAIL load_accept: got stall=%b sel=%b addr=%h, want 1 0 0040", a_stall, a_sel, mif_a.mem_addr);
        end
        step();
        op_valid_a = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_stall, a_sel, mif_a.mem_rw, mif_a.mem_addr} !== {1'b1, 1'b1, 1'b1, 16'h1234}) begin
            errors++;
            $display("FAIL load_access: got stall=%b sel=%b rw=%b addr=%h, want 1 1 1 1234",
                     a_stall, a_sel, mif_a.mem_rw, mif_a.mem_addr);
        end
        step();
        @(negedge clk);
        checks++;
        if ({a_wbv, a_ldr, a_stall, a_sel} !== {1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL load_done: got wbv=%b ldr=%b stall=%b sel=%b, want 1 1 0 0", a_wbv, a_ldr, a_stall, a_sel);
        end
        step();
        @(negedge clk);
        checks++;
        if (a_wbv !== 1'b0) begin
            errors++;
            $display("FAIL load_strobe_len: got wbv=%b, want 0", a_wbv);
        end
    endtask

    task automatic test_store();
        int rw0 = 0, bad = 0, wbv = 0;
        step();
        opcode = OP_STR; source1 = 32'h10; source2 = 32'hCAFE_0001;
        mif_b.mem_ready = 1'b1; op_valid_b = 1'b1;
        step();
        op_valid_b = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mif_b.mem_rw === 1'b0) begin
                rw0++;
                if (mif_b.mem_addr !== 16'h0010 || mif_b.mem_wdata !== 32'hCAFE_0001 || b_sel !== 1'b1) bad++;
            end
            if (b_wbv) wbv++;
        end
        checks++;
        if (rw0 != 4) begin
            errors++;
            $display("FAIL store_cycles: got %0d write cycles, want 4", rw0);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL store_bus: got %0d cycles with wrong addr/wdata/sel, want 0", bad);
        end
        checks++;
        if (wbv != 0) begin
            errors++;
            $display("FAIL store_no_wb: got %0d wb_valid cycles, want 0", wbv);
        end
    endtask

    task automatic test_alu();
        step();
        opcode = 4'b0001; alu_result = 32'd7; op_valid_a = 1'b1;
        sb.push_back('{32'd7, 1'b0});
        @(negedge clk);
        checks++;
        if (a_stall !== 1'b0) begin
            errors++;
            $display("FAIL alu_stall_accept: got stall=%b, want 0", a_stall);
        end
        step();
        op_valid_a = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_wbv, a_ldr, a_stall, a_wbd} !== {1'b1, 1'b0, 1'b0, 32'd7}) begin
            errors++;
            $display("FAIL alu_wb: got wbv=%b ldr=%b stall=%b data=%h, want 1 0 0 7", a_wbv, a_ldr, a_stall, a_wbd);
        end
    endtask

    task automatic test_timeout();
        int acc = 0, errs = 0, err_at = -1, wbv = 0;
        step();
        opcode = OP_LDR; source1 = 32'h0BAD; mif_a.mem_ready = 1'b0; op_valid_a = 1'b1;
        step();
        op_valid_a = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (a_sel) acc++;
            if (a_err) begin errs++; err_at = i; end
            if (a_wbv) wbv++;
        end
        checks++;
        if (acc != 8) begin
            errors++;
            $display("FAIL timeout_access_cycles: got %0d, want 8", acc);
        end
        checks++;
        if (errs != 1 || err_at != 8) begin
            errors++;
            $display("FAIL timeout_err: got %0d pulses at cycle %0d, want 1 at 8", errs, err_at);
        end
        checks++;
        if (wbv != 0) begin
            errors++;
            $display("FAIL timeout_no_wb: got %0d wb_valid cycles, want 0", wbv);
        end
    endtask

    task automatic test_back_to_back();
        step();
        opcode = OP_LDR; source1 = 32'h2000; mif_a.mem_rdata = 32'h1111_1111;
        mif_a.mem_ready = 1'b1; op_valid_a = 1'b1;
        sb.push_back('{32'h1111_1111, 1'b1});
        step();
        source1 = 32'h3000;
        sb.push_back('{32'h2222_2222, 1'b1});
        @(negedge clk);
        checks++;
        if (mif_a.mem_addr !== 16'h2000) begin
            errors++;
            $display("FAIL b2b_first_addr: got %h, want 2000", mif_a.mem_addr);
        end
        step();
        mif_a.mem_rdata = 32'h2222_2222;
        @(negedge clk);
        checks++;
        if ({a_stall, a_wbv, a_sel} !== {1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL b2b_done: got stall=%b wbv=%b sel=%b, want 0 1 0", a_stall, a_wbv, a_sel);
        end
        step();
        @(negedge clk);
        checks++;
        if ({a_stall, a_sel} !== {1'b1, 1'b0}) begin
            errors++;
            $display("FAIL b2b_accept: got stall=%b sel=%b, want 1 0", a_stall, a_sel);
        end
        step();
        op_valid_a = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_sel, mif_a.mem_addr} !== {1'b1, 16'h3000}) begin
            errors++;
            $display("FAIL b2b_second_addr: got sel=%b addr=%h, want 1 3000", a_sel, mif_a.mem_addr);
        end
        step();
        @(negedge clk);
        checks++;
        if (a_wbv !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_wb: got wbv=%b, want 1", a_wbv);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        step();
        opcode = OP_LDR; source1 = 32'h0555; mif_a.mem_ready = 1'b0; op_valid_a = 1'b1;
        step();
        op_valid_a = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_sel, mif_a.mem_addr, mif_a.mem_rw, a_stall, a_wbv, a_err, a_ldr} !==
            {1'b0, 16'h0040, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_ctrl: got sel=%b addr=%h rw=%b stall=%b wbv=%b err=%b ldr=%b",
                     a_sel, mif_a.mem_addr, mif_a.mem_rw, a_stall, a_wbv, a_err, a_ldr);
        end
        checks++;
        if (a_wbd !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_data: got wb_data=%h, want 0", a_wbd);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (a_wbv || a_err || a_sel) bad++;
        end
        step();
        rst_n = 1'b1;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_hold: got %0d active cycles during reset, want 0", bad);
        end
        step();
        source1 = 32'h0777; mif_a.mem_ready = 1'b1; mif_a.mem_rdata = 32'hABCD_0123; op_valid_a = 1'b1;
        sb.push_back('{32'hABCD_0123, 1'b1});
        step();
        op_valid_a = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_sel, mif_a.mem_addr} !== {1'b1, 16'h0777}) begin
            errors++;
            $display("FAIL reset_fresh_addr: got sel=%b addr=%h, want 1 0777", a_sel, mif_a.mem_addr);
        end
        step();
        @(negedge clk);
        checks++;
        if (a_wbv !== 1'b1) begin
            errors++;
            $display("FAIL reset_fresh_wb: got wbv=%b, want 1", a_wbv);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_alu();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        repeat (3) step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d write-backs missing, want 0", sb.size());
        end
        checks++;
        if (err_cnt != 1) begin
            errors++;
            $display("FAIL err_total: got %0d err pulses, want 1", err_cnt);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multi-cycle load/store controller for the CPU memory stage. It replaces the purely combinational LDR/STR steering with a registered state machine that is parametrised in address/data width, memory wait states and timeout. It arbitrates the shared RAM bus between instruction fetch and data access, stalls the pipeline while an access is outstanding, and returns a registered write-back value (load data or ALU result).

## Interface
Parameters:
- `ADDR_W`, default 16: RAM address width; must be ≤ `DATA_W`.
- `DATA_W`, default 32: register and RAM data width.
- `WAIT_STATES`, default 0: minimum cycles held in ACCESS before `mem_ready` is sampled (0..15).
- `TIMEOUT`, default 64: maximum cycles in ACCESS without a qualifying `mem_ready` before abort; must be > `WAIT_STATES`.

Ports (`name` direction width: meaning):
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `op_valid` in 1: memory-stage instruction present.
- `opcode` in 4: `4'b1001` is LDR, `4'b1010` is STR, anything else is a non-memory op.
- `source1` in DATA_W: address operand; bits [ADDR_W-1:0] are used.
- `source2` in DATA_W: store data.
- `alu_result` in DATA_W: result for non-memory ops.
- `fetch_addr` in ADDR_W: PC address for instruction fetch.
- `mem_addr` out ADDR_W: RAM address.
- `mem_en` out 1: RAM enable.
- `mem_rw` out 1: 1 = read, 0 = write.
- `mem_wdata` out DATA_W: RAM write data.
- `mem_rdata` in DATA_W: RAM read data.
- `mem_ready` in 1: RAM completion.
- `address_sel` out 1: 1 = data access owns the bus, 0 = fetch owns it.
- `ldr_sel` out 1: write-back source is load data.
- `stall` out 1: freeze fetch/decode and hold the memory-stage inputs.
- `wb_valid` out 1: one-cycle write-back strobe.
- `wb_data` out DATA_W: write-back value.
- `err` out 1: one-cycle timeout pulse.

## Operation
- States: IDLE, ACCESS, DONE.
- **IDLE**
  - `mem_addr` = `fetch_addr`; `mem_en` = 1; `mem_rw` = 1; `address_sel` = 0.
  - `op_valid` with LDR or STR: latch the address (`source1[ADDR_W-1:0]`), `source2` and a load/store flag; go to ACCESS; clear the wait counter.
  - `op_valid` with any other opcode: next cycle `wb_valid` = 1, `wb_data` = `alu_result`, `ldr_sel` = 0; stay in IDLE.
- **ACCESS**
  - Drive the latched address; `address_sel` = 1; `mem_en` = 1; `mem_rw` = 1 for LDR, 0 for STR; `mem_wdata` = latched store data.
  - The counter increments every cycle.
  - When counter ≥ `WAIT_STATES` and `mem_ready` = 1: for LDR, capture `mem_rdata` into `wb_data`; go to DONE.
  - When counter reaches `TIMEOUT` - 1 with no completion: pulse `err`, go to IDLE, no write-back.
- **DONE**
  - LDR: `wb_valid` = 1, `ldr_sel` = 1.
  - STR: `wb_valid` = 0.
  - Unconditionally go to IDLE.
- `mem_ready` is ignored outside ACCESS and before the wait count is met.
- Reset mid-access: return to IDLE immediately; no write-back and no `err`. A write already presented to the RAM is not rolled back.

## Timing
- `stall` is combinational: (IDLE ∧ `op_valid` ∧ LDR/STR) ∨ ACCESS. It is 0 in DONE.
- Reset values:
  - state = IDLE, counter = 0.
  - `wb_valid` = 0, `wb_data` = 0, `ldr_sel` = 0, `err` = 0.
  - Latched address and store data = 0.
  - `mem_en` = 1, `mem_rw` = 1, `address_sel` = 0, `mem_addr` = `fetch_addr`.
- Latency, accept edge T:
  - ACCESS from T+1.
  - Earliest completion edge is T+1+`WAIT_STATES` (ready already high); DONE follows that edge, so `wb_valid` is high one cycle later.
  - With `WAIT_STATES` = 0 and ready constantly high, a load occupies 3 cycles: IDLE accept, ACCESS, DONE.
- Non-memory op: `wb_valid` one cycle after accept, no stall.
- Back-to-back: a memory op presented during DONE is not accepted. Because `stall` = 0 in DONE, the pipeline holds that op in place and it is accepted in the next IDLE cycle.
- `wb_valid` and `err` are registered and are never high in the same cycle.

## Structure
- Shared package (`cpu_pkg`): `OP_LDR` = 4'b1001, `OP_STR` = 4'b1010, state enum {IDLE, ACCESS, DONE}.
- One natural sub-module: `wait_counter`, a parametrised up-counter with clear, `wait_met` (≥ `WAIT_STATES`) and `timeout_hit` outputs.
- The fetch/data address mux stays inline.

## Test plan
- Reset, then idle → `mem_addr` = `fetch_addr` = 0x0040, `mem_rw` = 1, `address_sel` = 0, `stall` = 0, `wb_valid` = 0.
- LDR with `source1` = 0x0001_1234, `WAIT_STATES` = 0, ready high, `mem_rdata` = 0xDEAD_BEEF → `mem_addr` = 0x1234 for one cycle, `stall` high 2 cycles, then `wb_valid` = 1, `ldr_sel` = 1, `wb_data` = 0xDEAD_BEEF.
- STR with `source1` = 0x10, `source2` = 0xCAFE_0001, `WAIT_STATES` = 3, ready high → `mem_rw` = 0 for exactly 4 ACCESS cycles, `mem_wdata` = 0xCAFE_0001, no `wb_valid`.
- ADD-class opcode 4'b0001 with `alu_result` = 7 → `wb_valid` = 1, `wb_data` = 7, `ldr_sel` = 0, `stall` never asserted.
- LDR with `mem_ready` held 0, `TIMEOUT` = 8 → `err` pulses once after 8 ACCESS cycles, return to IDLE, no `wb_valid`.
- `rst_n` asserted during an ACCESS load → all outputs take reset values asynchronously; after release, a fresh LDR completes normally.
